// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver: scan_clk_i is synchronized and used as an advance strobe.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scanner #(
   parameter int unsigned DIGITS           = 4,
   parameter bit          ANODE_ACTIVE_LOW = 1'b1,
   parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  scan_clk_i,
   input  logic [4*DIGITS-1:0]   value_i,
   input  logic [DIGITS-1:0]     dp_i,
   input  logic [DIGITS-1:0]     digit_en_i,
   output logic [DIGITS-1:0]     an_o,
   output logic [6:0]            seg_o,
   output logic                  dp_o
);

   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned VAL_W = 4 * DIGITS;
   localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ANODE_ACTIVE_LOW}};
   localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic              DP_OFF  = SEG_ACTIVE_LOW;

   typedef enum logic {
      ST_HOLD  = 1'b0,
      ST_BLANK = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic                s1_q, s2_q, s3_q;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [VAL_W-1:0]    val_sh_q, val_sh_d;
   logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
   logic [DIGITS-1:0]   en_sh_q, en_sh_d;
   logic                on_q, on_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;

   logic                adv;
   logic                wrap;
   logic                capture;
   logic [IDX_W-1:0]    next_idx;
   logic [DIGITS-1:0]   lz_mask;
   logic                next_on;

   // Active-high gfedcba hex decode
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign adv      = s2_q & ~s3_q;
   assign wrap     = (idx_q == IDX_W'(DIGITS - 1));
   assign capture  = adv & wrap;
   assign next_idx = wrap ? '0 : idx_q + IDX_W'(1);

   // Frame values as they will be after this cycle: inputs on a wrap, shadows otherwise
   assign val_sh_d = capture ? value_i    : val_sh_q;
   assign dp_sh_d  = capture ? dp_i       : dp_sh_q;
   assign en_sh_d  = capture ? digit_en_i : en_sh_q;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   // Digit k>0 is blank when it and every more-significant nibble are zero
   always_comb begin
      logic upper_zero;
      lz_mask    = '0;
      upper_zero = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         upper_zero = upper_zero & (val_sh_d[4*k +: 4] == 4'h0);
         lz_mask[k] = upper_zero;
      end
   end
`else
   assign lz_mask = '0;
`endif

   assign next_on = en_sh_d[next_idx] & ~lz_mask[next_idx];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_HOLD;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s3_q     <= 1'b0;
         idx_q    <= IDX_W'(DIGITS - 1);
         val_sh_q <= '0;
         dp_sh_q  <= '0;
         en_sh_q  <= '0;
         on_q     <= 1'b0;
         an_q     <= AN_OFF;
         seg_q    <= SEG_OFF;
         dp_q     <= DP_OFF;
      end else begin
         state_q  <= state_d;
         s1_q     <= scan_clk_i;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         idx_q    <= idx_d;
         val_sh_q <= val_sh_d;
         dp_sh_q  <= dp_sh_d;
         en_sh_q  <= en_sh_d;
         on_q     <= on_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
      end
   end

   // Advance loads the new digit with anodes off; the following cycle lights the anode
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      on_d    = on_q;
      an_d    = an_q;
      seg_d   = seg_q;
      dp_d    = dp_q;
      if (adv) begin
         idx_d   = next_idx;
         on_d    = next_on;
         seg_d   = next_on ? (hex7(val_sh_d[4*next_idx +: 4]) ^ SEG_OFF) : SEG_OFF;
         dp_d    = (next_on & dp_sh_d[next_idx]) ^ DP_OFF;
         an_d    = AN_OFF;
         state_d = ST_BLANK;
      end else if (state_q == ST_BLANK) begin
         an_d    = on_q ? ((DIGITS'(1) << idx_q) ^ AN_OFF) : AN_OFF;
         state_d = ST_HOLD;
      end
   end

   assign an_o  = an_q;
   assign seg_o = seg_q;
   assign dp_o  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (DIGITS=4, active-low anodes and segments).
module tb_seven_seg_scanner;

   localparam int D = 4;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   localparam bit LZ_EN = 1'b1;
`else
   localparam bit LZ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        scan;
   logic [15:0] value;
   logic [3:0]  dp_req;
   logic [3:0]  en;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   seven_seg_scanner #(.DIGITS(D), .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .scan_clk_i(scan), .value_i(value),
      .dp_i(dp_req), .digit_en_i(en), .an_o(an), .seg_o(seg), .dp_o(dp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         at;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      string      tag;
   } exp_t;

   exp_t q[$];
   int compared = 0;
   int mismatched = 0;

   // Reference display model: which digit is showing and the frame it belongs to
   logic [6:0]  seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   int          m_idx;
   logic [15:0] m_val;
   logic [3:0]  m_dp;
   logic [3:0]  m_en;

   function automatic bit lz_blank(int k);
      return LZ_EN && (k > 0) && ((m_val >> (4 * k)) == 16'h0);
   endfunction

   function automatic exp_t mk(int at, bit blank, string tag);
      exp_t e;
      bit on;
      logic [3:0] nib;
      logic [3:0] one;
      on    = m_en[m_idx] && !lz_blank(m_idx);
      nib   = m_val[4*m_idx +: 4];
      one   = 4'b0001 << m_idx;
      e.at  = at;
      e.an  = (on && !blank) ? ~one : 4'hF;
      e.seg = on ? ~seg_tbl[nib] : 7'h7F;
      e.dp  = (on && m_dp[m_idx]) ? 1'b0 : 1'b1;
      e.tag = $sformatf("%s_d%0d_%s", tag, m_idx, blank ? "blank" : "lit");
      return e;
   endfunction

   function automatic exp_t idle(int at, string tag);
      exp_t e;
      e.at = at; e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.tag = tag;
      return e;
   endfunction

   task automatic check(exp_t e);
      compared++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
         mismatched++;
         $display("FAIL %s @cyc %0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                  e.tag, cyc, an, seg, dp, e.an, e.seg, e.dp);
      end
   endtask

   // Monitor: compares the head of the queue when its cycle comes up
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].at <= cyc) begin
         e = q.pop_front();
         if (e.at < cyc) begin
            compared++;
            mismatched++;
            $display("FAIL %s missed: expected at cyc %0d, now %0d", e.tag, e.at, cyc);
         end else begin
            check(e);
         end
      end
   end

   task automatic model_reset();
      m_idx = D - 1;
      m_val = '0;
      m_dp  = '0;
      m_en  = '0;
   endtask

   // One scan_clk_i pulse (high h clocks, low l clocks); called just after a negedge
   task automatic advance(int h, int l, string tag);
      int c;
      exp_t lit;
      c     = cyc;
      scan  = 1'b1;
      m_idx = (m_idx + 1) % D;
      if (m_idx == 0) begin
         m_val = value;
         m_dp  = dp_req;
         m_en  = en;
      end
      q.push_back(mk(c + 3, 1'b1, tag));
      lit = mk(c + 4, 1'b0, tag);
      q.push_back(lit);
      repeat (h) @(negedge clk);
      scan = 1'b0;
      repeat (l) @(negedge clk);
      lit.at  = cyc + 2;
      lit.tag = {lit.tag, "_hold"};
      q.push_back(lit);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain_timeout: %0d checks still pending, required 0", q.size());
         q.delete();
      end
   endtask

   task automatic do_reset(string tag);
      drain();
      rst_n = 1'b0;
      #1;
      check(idle(cyc, {tag, "_async"}));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      q.push_back(idle(cyc + 2, {tag, "_release"}));
      repeat (5) @(negedge clk);
      q.push_back(idle(cyc + 1, {tag, "_no_scan"}));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1; scan = 1'b0; value = '0; dp_req = '0; en = '0;
      model_reset();
      #1 rst_n = 1'b0;
      #1 check(idle(cyc, "por_async"));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      q.push_back(idle(cyc + 3, "por_no_scan"));
      repeat (5) @(negedge clk);

      // Latency and first wrap capture
      value = 16'h0000; dp_req = 4'b0000; en = 4'hF;
      for (int i = 0; i < 4; i++) advance(2, 4, "latency");

      // Decode with decimal point on digit 2
      value = 16'h12AF; dp_req = 4'b0100;
      for (int i = 0; i < 4; i++) advance(2, 3, "decode");

      // Tearing: change mid-frame, new value only from next wrap
      value = 16'h1111; dp_req = 4'b0000;
      advance(2, 2, "tear_old");
      advance(2, 2, "tear_old");
      value = 16'h2222;
      advance(2, 2, "tear_old");
      advance(2, 2, "tear_old");
      for (int i = 0; i < 4; i++) advance(2, 2, "tear_new");

      // Disabled digit and a long stall with scan held high
      value = 16'h9876; en = 4'b1011;
      for (int i = 0; i < 4; i++) advance(3, 5, "enable");
      advance(1000, 3, "stall");
      for (int i = 0; i < 3; i++) advance(2, 3, "enable");
      en = 4'hF;

      // Leading-zero patterns
      value = 16'h0050;
      for (int i = 0; i < 4; i++) advance(2, 3, "lz0050");
      value = 16'h0000;
      for (int i = 0; i < 4; i++) advance(2, 3, "lz0000");

      // Random frames with inputs changing on every advance
      for (int i = 0; i < 60; i++) begin
         value  = 16'($urandom);
         dp_req = 4'($urandom);
         en     = 4'($urandom);
         advance(int'($urandom_range(1, 3)), int'($urandom_range(2, 4)), "rand");
      end

      do_reset("midscan");
      for (int i = 0; i < 8; i++) begin
         value  = 16'($urandom);
         dp_req = 4'($urandom);
         en     = 4'($urandom);
         advance(int'($urandom_range(1, 3)), int'($urandom_range(2, 4)), "post_reset");
      end

      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexed driver for a multi-digit seven-segment display, clocked by the system clock.
- Its scan rate comes from a clock-divider output: the divided clock feeds `scan_clk_i` and is used only as a sampled strobe, never as a clock.
- Each rising edge of `scan_clk_i` advances to the next digit, decodes one hex nibble and drives one anode, with a one-cycle blanking gap to prevent ghosting.

Parameters:
- `DIGITS`, 4: number of display digits; legal range 2..8.
- `ANODE_ACTIVE_LOW`, 1: 1 means an asserted anode is driven 0; 0 means asserted is 1.
- `SEG_ACTIVE_LOW`, 1: 1 means a lit segment or decimal point is driven 0; 0 means lit is 1.

Ports:
- `clk_i`, input, 1: system clock; all flops on its rising edge.
- `rst_ni`, input, 1: asynchronous active-low reset.
- `scan_clk_i`, input, 1: divided scan clock, treated as an asynchronous level.
- `value_i`, input, 4*DIGITS: hex nibbles; nibble k (bits 4k+3:4k) belongs to digit k, and digit 0 is least significant.
- `dp_i`, input, DIGITS: decimal-point request per digit.
- `digit_en_i`, input, DIGITS: per-digit enable; a disabled digit is never lit.
- `an_o`, output, DIGITS: anode drive, one-hot when asserted.
- `seg_o`, output, 7: segment drive, with bit 0 = a through bit 6 = g.
- `dp_o`, output, 1: decimal-point drive.

Behaviour:
- **Reset (async assert, sync release via `rst_ni`):**
  - All outputs go inactive: `an_o` all deasserted, `seg_o` all unlit, `dp_o` unlit.
  - Synchronizer and edge flops clear to 0, digit index resets to DIGITS-1, shadow registers clear to 0, blank flag clears.
- **Synchronizer:** `scan_clk_i` passes through two flops, s1 then s2, followed by a history flop s3. The advance strobe is `s2 & ~s3`.
- **Advance latency:**
  - `scan_clk_i` rises and is captured by s1 at clk edge N, and by s2 at edge N+1.
  - At edge N+2 the unit registers:
    - index = (index==DIGITS-1) ? 0 : index+1;
    - `seg_o` and `dp_o` take the new digit's pattern;
    - `an_o` goes all deasserted and the blank flag is set.
  - At edge N+3 the blank flag clears and `an_o` asserts only the new index, provided that digit is enabled.
- **Stable input:** if `scan_clk_i` is held high or held low, there is no further advance and the current digit stays lit indefinitely.
- **Wrap capture:** on an advance that wraps the index to 0, `value_i`, `dp_i` and `digit_en_i` are copied into shadow registers in that same cycle. All decoding uses the shadows, so a frame never shows mixed old and new values.
  - After reset, the first advance wraps from DIGITS-1 to 0, so inputs are captured immediately.
- **Disabled digit (shadow `digit_en` bit = 0):**
  - The digit's slot is still consumed, keeping the per-digit duty cycle at 1/DIGITS.
  - `an_o` stays deasserted and `seg_o`/`dp_o` are driven unlit.
- **Hex decode, active-high gfedcba form:**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - When SEG_ACTIVE_LOW=1, `seg_o` and `dp_o` are bitwise inverted; when ANODE_ACTIVE_LOW=1, `an_o` is inverted.
- **Glitch-free outputs:** `an_o`, `seg_o` and `dp_o` are driven directly from flops, never from combinational logic.
- **Back-to-back advances:** when advances arrive every 3 clocks or more, every digit gets at least 1 lit cycle. Faster toggling of `scan_clk_i` is outside the supported range; it must not hang the unit, though digits may skip.
- **Reset mid-scan:** all outputs are blanked immediately, without waiting for the clock; the frame restarts from the wrap capture.

Optional Feature:
- Macro: `SEVEN_SEG_LEADING_ZERO_BLANK_EN`.
- **Defined:** digit k>0 is blanked (treated as disabled) when its shadow nibble and all more-significant shadow nibbles are 0. Digit 0 is never blanked by this rule.
- **Undefined:** all enabled digits display, including leading zeros.
- The blanking decision uses shadow values only, so it is frame-consistent.

Test Plan:
- Reset: assert `rst_ni`=0 mid-frame with DIGITS=4 and both ACTIVE_LOW=1 -> same cycle `an_o`=4'hF, `seg_o`=7'h7F, `dp_o`=1; no anode asserts until the first scan edge after release.
- Latency: `scan_clk_i` rises just before clk edge N -> `an_o`=4'hF at edge N+2; `an_o`=4'hE (digit 0) at N+3; `seg_o`=~7'h3F when `value_i`=16'h0000.
- Decode: `value_i`=16'h12AF, `dp_i`=4'b0100, all digits enabled -> successive slots show `seg_o`=~71, ~77, ~5B, ~06 with anodes E, D, B, 7; `dp_o`=0 only in digit 2's slot.
- Tearing: change `value_i` from 16'h1111 to 16'h2222 while index=1 -> digits 2 and 3 still show 1 in this frame; all digits show 2 from the next wrap.
- Enable and stall: `digit_en_i`=4'b1011 -> digit 2's slot has `an_o`=4'hF for its whole duration; then holding `scan_clk_i` high for 1000 clks -> no index change.
- With `SEVEN_SEG_LEADING_ZERO_BLANK_EN`: `value_i`=16'h0050 -> digits 3 and 2 blank, digit 1 shows 5, digit 0 shows 0; `value_i`=16'h0000 -> only digit 0 lit, showing 0.
